// File: rtl/keypad_pkg.sv
// Shared types, key codes and the matrix-position decoder for the keypad scanner.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SCAN       = 2'd0;
  localparam state_t ST_PRESS_DB   = 2'd1;
  localparam state_t ST_HELD       = 2'd2;
  localparam state_t ST_RELEASE_DB = 2'd3;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;

  // Column 3 holds A..D; rows 0-2 of columns 0-2 are the digits 1..9 in reading order.
  function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] r4;
    logic [3:0] c4;
    r4 = {2'b00, row};
    c4 = {2'b00, col};
    if (col == 2'd3) return KEY_PLUS + r4;
    if (row == 2'd3) begin
      case (col)
        2'd0:    return KEY_STAR;
        2'd1:    return 4'h0;
        default: return KEY_HASH;
      endcase
    end
    return r4 * 4'd3 + c4 + 4'd1;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row returns.
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Idle rows read high, so reset to the released level to avoid a phantom press.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, key decode, one-cycle strobes.
// Optional auto-repeat of digit keys is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keypad_input,
  output logic       digit_valid,
  output logic       operator_input,
  output logic       equal_input,
  output logic       clear_req,
  output logic       key_held
);

  localparam int DWW = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV must be >= 3, DEBOUNCE_CYCLES and REPEAT_CYCLES >= 1");
  end

  state_t         state;
  logic [1:0]     col_idx;
  logic [1:0]     lat_row;
  logic [DWW-1:0] dwell_cnt;
  logic [DBW-1:0] db_cnt;
  logic [3:0]     row_sync;
  logic [1:0]     low_row;
  logic           row_any;
  logic           armed;
  logic [1:0]     clean_cols;
  logic [3:0]     new_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_CYCLES - 1);
  logic [RPW-1:0] rep_cnt;
`endif

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (row_sync)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    low_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) low_row = r[1:0];
    end
  end

  assign row_any  = ~&row_sync;
  assign col_out  = ~(4'b0001 << col_idx);
  assign new_code = key_decode(lat_row, col_idx);

  // After reset a key may still be down; a full sweep with no row low arms acceptance,
  // so such a key must be released and pressed again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_SCAN;
      col_idx        <= 2'd0;
      lat_row        <= 2'd0;
      dwell_cnt      <= '0;
      db_cnt         <= '0;
      armed          <= 1'b0;
      clean_cols     <= 2'd0;
      keypad_input   <= 4'h0;
      digit_valid    <= 1'b0;
      operator_input <= 1'b0;
      equal_input    <= 1'b0;
      clear_req      <= 1'b0;
      key_held       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt        <= '0;
`endif
    end else begin
      digit_valid    <= 1'b0;
      operator_input <= 1'b0;
      equal_input    <= 1'b0;
      clear_req      <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (row_any && armed) begin
              lat_row <= low_row;
              db_cnt  <= '0;
              state   <= ST_PRESS_DB;
            end else begin
              col_idx <= col_idx + 2'd1;
              if (!armed) begin
                if (row_any)                 clean_cols <= 2'd0;
                else if (clean_cols == 2'd3) armed      <= 1'b1;
                else                         clean_cols <= clean_cols + 2'd1;
              end
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        ST_PRESS_DB: begin
          if (row_sync[lat_row]) begin
            db_cnt  <= '0;
            col_idx <= col_idx + 2'd1;
            state   <= ST_SCAN;
          end else if (db_cnt == DB_LAST) begin
            db_cnt         <= '0;
            keypad_input   <= new_code;
            digit_valid    <= is_digit(new_code);
            operator_input <= (new_code == KEY_PLUS) || (new_code == KEY_MINUS);
            equal_input    <= (new_code == KEY_HASH);
            clear_req      <= (new_code == KEY_STAR);
            key_held       <= 1'b1;
            state          <= ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt        <= '0;
`endif
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (row_sync[lat_row]) begin
            db_cnt <= '0;
            state  <= ST_RELEASE_DB;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (is_digit(keypad_input)) begin
            if (rep_cnt == REP_LAST) begin
              rep_cnt     <= '0;
              digit_valid <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
`endif
        end
        ST_RELEASE_DB: begin
          if (!row_sync[lat_row]) begin
            db_cnt <= '0;
            state  <= ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            key_held <= 1'b0;
            col_idx  <= col_idx + 2'd1;
            state    <= ST_SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule
